one_pattern_generator: RTL
==========================

ONE_PATTERN_GENERATOR -- requirements
Module: one_pattern_generator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of each generated word (legal range 2..15).
REQ-002 SHALL have parameter CNT_WIDTH, default 4: width of count and index fields; must satisfy 2^CNT_WIDTH > DATA_WIDTH.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Ports SHALL be, in this order:
- clk  input  1  clock; all logic on rising edge.
- rstn  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  generator can accept a request.
- req_num_one  input  CNT_WIDTH  required count of 1 bits.
- req_min_index  input  CNT_WIDTH  required lowest set-bit index (bit 0 = LSB).
- req_max_index  input  CNT_WIDTH  required highest set-bit index.
- req_error  output  1  one-cycle pulse: request was illegal.
- data_valid  output  1  data_out holds a generated word.
- data_ready  input  1  downstream accepts the word.
- data_out  output  DATA_WIDTH  generated word.
- data_last  output  1  data_out is the final word of the current request.

Function
REQ-005 SHALL enumerate every DATA_WIDTH word with exactly req_num_one ones, lowest set bit at req_min_index and highest at req_max_index; this is the inverse of the team's bit-1 counter.
REQ-006 SHALL emit the words in strictly ascending numeric order, one word per transfer, with no duplicates and no omissions.
REQ-007 SHALL accept a request when req_valid && req_ready; req_ready SHALL be high only in IDLE and low while a request is being generated.
REQ-008 SHALL, when req_num_one = 0, emit the single word 0 with data_last = 1, ignoring both index fields.
REQ-009 SHALL treat a request as illegal if any of the following holds:
- req_num_one > DATA_WIDTH;
- req_max_index >= DATA_WIDTH;
- req_min_index > req_max_index;
- req_num_one = 1 and req_min_index != req_max_index;
- req_num_one >= 2 and req_min_index = req_max_index;
- req_num_one > req_max_index - req_min_index + 1.
This check SHALL be skipped when req_num_one = 0.
REQ-010 SHALL respond to an illegal request by pulsing req_error for exactly the cycle after acceptance; it SHALL emit no word, and req_ready SHALL stay high.
REQ-011 Latency: data_valid SHALL rise the cycle after a legal request is accepted.
REQ-012 The state machine SHALL have three states:
- IDLE -> GEN on a legal accept;
- GEN -> GEN on a transfer that is not the last;
- GEN -> IDLE on the transfer of the last word, with req_ready high in the following cycle.
REQ-013 The first word SHALL have bits min and max set (or bit min only when num_one = 1), with the num_one - 2 interior ones packed against min+1.
REQ-014 Each following word SHALL be the next-larger interior combination (Gosper successor restricted to bits min+1..max-1), computed within one cycle.
REQ-015 data_last SHALL be high exactly on the word whose interior ones are packed against max-1; a request with one legal word SHALL give data_last on that first word.
REQ-016 While data_valid && !data_ready, data_out and data_last SHALL hold stable; back-to-back transfers SHALL proceed with no idle cycles.
REQ-017 data_valid SHALL NOT drop in GEN until the last word transfers.

Reset
REQ-018 While rstn = 0, the following SHALL hold asynchronously:
- state = IDLE;
- req_ready = 1, req_error = 0, data_valid = 0, data_out = 0, data_last = 0.
REQ-019 A reset asserted in GEN SHALL abandon the request; after rstn rises, the block SHALL accept a new request with no stale word emitted.

Configuration
REQ-020 With macro ONE_PATTERN_GEN_COUNT_EN defined, the block SHALL add output port word_count (16 bits):
- zeroed on accept;
- incremented on every transfer;
- valid on and after the data_last transfer;
- saturating at 0xFFFF;
- reset to 0.
REQ-021 Without ONE_PATTERN_GEN_COUNT_EN, word_count and its counter SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-022 Request num=4, min=1, max=5, data_ready=1 -> words 0x2E, 0x36, 0x3A on consecutive cycles; data_last only on 0x3A; req_ready high one cycle later.
REQ-023 Request num=6, min=1, max=6 -> single word 0x7E with data_last=1; request num=0 -> single word 0x00 with data_last=1.
REQ-024 Request num=2, min=3, max=3 -> req_error high for one cycle, data_valid stays 0; a further request num=5, min=0, max=3 -> req_error pulse.
REQ-025 Request num=3, min=0, max=7 with data_ready toggling 1,0,0,1... -> six words 0x83, 0x85, 0x89, 0x91, 0xA1, 0xC1, each held stable while data_ready=0.
REQ-026 Reset pulsed after the second word of REQ-022 -> outputs return to their reset values at once; a fresh num=4, min=1, max=5 request then yields the full three-word sequence.
REQ-027 With ONE_PATTERN_GEN_COUNT_EN defined, the REQ-025 stimulus -> word_count = 6 at data_last.

Source files
------------

// File: rtl/one_pattern_generator.sv
// Enumerates every word with a given count of ones and given lowest/highest set bits, in ascending order.
// Optional feature: define ONE_PATTERN_GEN_COUNT_EN to add the 16-bit word_count output.
module one_pattern_generator #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [CNT_WIDTH-1:0]  req_num_one,
  input  logic [CNT_WIDTH-1:0]  req_min_index,
  input  logic [CNT_WIDTH-1:0]  req_max_index,
  output logic                  req_error,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_last
`ifdef ONE_PATTERN_GEN_COUNT_EN
  ,
  output logic [15:0]           word_count
`endif
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = CNT_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    ERR
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DW-1:0] r_data;
  logic [DW-1:0] r_base;
  logic [DW-1:0] r_int;
  logic [DW-1:0] r_lpat;
  logic [CW-1:0] r_sh;
  logic          r_last;

  logic          w_acc;
  logic          w_xfer;
  logic          w_illegal;
  logic [CW:0]   w_span;
  logic [CW-1:0] w_k;
  logic [CW-1:0] w_n;
  logic [CW-1:0] w_sh;
  logic [DW-1:0] w_int0;
  logic [DW-1:0] w_lpat;
  logic [DW-1:0] w_base;
  logic [DW-1:0] w_int_init;
  logic [DW-1:0] w_first;
  logic          w_first_last;
  logic [DW-1:0] w_c;
  logic [DW-1:0] w_r;
  logic [CW-1:0] w_tz;
  logic [DW-1:0] w_nint;

  assign w_acc  = req_valid && req_ready;
  assign w_xfer = data_valid && data_ready;

  assign w_span = {1'b0, req_max_index} - {1'b0, req_min_index} + 1'b1;

  // Legality of the incoming request; a zero-ones request is always legal
  always_comb begin
    w_illegal = 1'b0;
    if (req_num_one != '0) begin
      w_illegal =
        (int'(req_num_one) > DW) ||
        (int'(req_max_index) >= DW) ||
        (req_min_index > req_max_index) ||
        ((req_num_one == CW'(1)) && (req_min_index != req_max_index)) ||
        ((req_num_one >= CW'(2)) && (req_min_index == req_max_index)) ||
        ({1'b0, req_num_one} > w_span);
    end
  end

  // Interior field spans bits min+1..max-1 and holds num_one-2 ones
  assign w_k    = req_num_one - CW'(2);
  assign w_n    = req_max_index - req_min_index - CW'(1);
  assign w_sh   = req_min_index + CW'(1);
  assign w_int0 = (DW'(1) << w_k) - DW'(1);
  assign w_lpat = w_int0 << (w_n - w_k);

  // First word of the request: endpoint bits plus interior packed low
  always_comb begin
    w_base       = '0;
    w_int_init   = '0;
    w_first_last = 1'b1;
    unique case (1'b1)
      (req_num_one == '0): begin
        w_base = '0;
      end
      (req_num_one == CW'(1)): begin
        w_base = DW'(1) << req_min_index;
      end
      default: begin
        w_base       = (DW'(1) << req_min_index) | (DW'(1) << req_max_index);
        w_int_init   = w_int0;
        w_first_last = (w_int0 == w_lpat);
      end
    endcase
    w_first = w_base | (w_int_init << w_sh);
  end

  // Gosper successor of the interior combination
  always_comb begin
    w_c  = r_int & (~r_int + DW'(1));
    w_r  = r_int + w_c;
    w_tz = '0;
    for (int i = DW - 1; i >= 0; i--) begin
      if (r_int[i]) w_tz = CW'(i);
    end
    w_nint = (((w_r ^ r_int) >> 2) >> w_tz) | w_r;
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and handshake outputs; ERR only reports and still accepts
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    req_error   = 1'b0;
    data_valid  = 1'b0;
    unique case (r_state)
      IDLE, ERR: begin
        req_ready = 1'b1;
        req_error = (r_state == ERR);
        if (w_acc) w_state_nxt = w_illegal ? ERR : GEN;
        else       w_state_nxt = IDLE;
      end
      GEN: begin
        data_valid = 1'b1;
        if (w_xfer && r_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Word datapath: load on accept, step on each non-final transfer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data <= '0;
      r_base <= '0;
      r_int  <= '0;
      r_lpat <= '0;
      r_sh   <= '0;
      r_last <= 1'b0;
    end else if (w_acc && !w_illegal) begin
      r_data <= w_first;
      r_base <= w_base;
      r_int  <= w_int_init;
      r_lpat <= w_lpat;
      r_sh   <= w_sh;
      r_last <= w_first_last;
    end else if (w_xfer && !r_last) begin
      r_data <= r_base | (w_nint << r_sh);
      r_int  <= w_nint;
      r_last <= (w_nint == r_lpat);
    end
  end

  assign data_out  = r_data;
  assign data_last = r_last;

`ifdef ONE_PATTERN_GEN_COUNT_EN
  logic [15:0] r_cnt;

  // Saturating count of words transferred for the current request
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                           r_cnt <= '0;
    else if (w_acc)                      r_cnt <= '0;
    else if (w_xfer && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
  end

  assign word_count = r_cnt;
`endif

endmodule
